// File: rtl/hpdmc_rdcapture.sv
// hpdmc_rdcapture: aligns IDDR2 read beats to READ commands and
// assembles burst words into a small FIFO for the bus interface.
module hpdmc_rdcapture #(
    parameter int DQ_WIDTH    = 16,
    parameter int BURST_BEATS = 4,
    parameter int MAX_LAT     = 7,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rd_issue,
    input  logic [2:0]            rd_latency,
    input  logic [DQ_WIDTH-1:0]   iddr_q0,
    input  logic [DQ_WIDTH-1:0]   iddr_q1,
    input  logic                  rd_ready,
    input  logic                  err_clr,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  rd_pending,
    output logic                  err_overflow,
    output logic                  err_overlap
);

    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 2 * DQ_WIDTH + 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_CAPT = 1'b1;

    logic [MAX_LAT-1:0] r_issue_sr;
    logic [LW-1:0]      r_lat_q;
    logic               r_state;
    logic [BW-1:0]      r_beat;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_err_ovf;
    logic               r_err_ovl;
    logic [EW-1:0]      r_mem [FIFO_DEPTH];

    logic [LW-1:0]      w_lat_in;
    logic               w_lat_load;
    logic               w_start;
    logic               w_state_nxt;
    logic [BW-1:0]      w_beat_nxt;
    logic               w_push_req;
    logic               w_push_last;
    logic               w_overlap;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf;
    logic [EW-1:0]      w_word;
    logic [EW-1:0]      w_rd_ent;

    // Out-of-range latencies are clamped rather than rejected.
    always_comb begin
        w_lat_in = LW'(rd_latency);
        if (rd_latency == 3'd0)
            w_lat_in = LW'(1);
        else if (int'(rd_latency) > MAX_LAT)
            w_lat_in = LW'(MAX_LAT);
    end

    assign w_lat_load = (r_issue_sr == '0) && (r_state == S_IDLE)
                        && !rd_issue;

    always_comb begin
        w_start = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (r_lat_q == LW'(i + 1))
                w_start = r_issue_sr[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_push_req  = 1'b0;
        w_push_last = 1'b0;
        w_overlap   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_push_req  = 1'b1;
                    w_push_last = (BURST_BEATS == 1);
                    w_beat_nxt  = BW'(1);
                    if (BURST_BEATS > 1)
                        w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                // A start here collides with the burst in progress.
                w_push_req = 1'b1;
                w_overlap  = w_start;
                w_beat_nxt = r_beat + BW'(1);
                if (r_beat == BW'(BURST_BEATS - 1)) begin
                    w_push_last = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && rd_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_ovf   = w_push_req && w_full && !w_pop;
    assign w_word  = {w_push_last, iddr_q0, iddr_q1};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_issue_sr <= '0;
            r_lat_q    <= LW'(1);
            r_state    <= S_IDLE;
            r_beat     <= '0;
        end else begin
            r_issue_sr <= {r_issue_sr[MAX_LAT-2:0], rd_issue};
            if (w_lat_load)
                r_lat_q <= w_lat_in;
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_word;
    end

    // Setting an error takes priority over clearing it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_ovl <= 1'b0;
        end else begin
            if (w_ovf)
                r_err_ovf <= 1'b1;
            else if (err_clr)
                r_err_ovf <= 1'b0;
            if (w_overlap)
                r_err_ovl <= 1'b1;
            else if (err_clr)
                r_err_ovl <= 1'b0;
        end
    end

    assign w_rd_ent     = r_mem[r_rptr];
    assign rd_valid     = w_valid;
    assign rd_data      = w_valid ? w_rd_ent[2*DQ_WIDTH-1:0] : '0;
    assign rd_last      = w_valid & w_rd_ent[EW-1];
    assign rd_pending   = (|r_issue_sr) | (r_state == S_CAPT) | w_valid;
    assign err_overflow = r_err_ovf;
    assign err_overlap  = r_err_ovl;

endmodule
